// File: rtl/move_pkg.sv
// Shared encodings and map-extent helpers for the move resolver.
package move_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PROBE  = 2'd1,
        DRAIN  = 2'd2,
        RESULT = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CAND_X  = 2'd0,
        CAND_Y  = 2'd1,
        CAND_XY = 2'd2
    } cand_e;

    typedef enum logic [1:0] {
        TL = 2'd0,
        TR = 2'd1,
        BL = 2'd2,
        BR = 2'd3
    } corner_e;

    localparam int unsigned DEF_GRID_W  = 8;
    localparam int unsigned DEF_GRID_H  = 8;
    localparam int unsigned DEF_CELL_PX = 60;

    localparam int unsigned MAP_PX_W = DEF_GRID_W * DEF_CELL_PX;
    localparam int unsigned MAP_PX_H = DEF_GRID_H * DEF_CELL_PX;

    // Pixel extent of a map axis for a given cell count and cell size.
    function automatic int unsigned map_extent(input int unsigned cells, input int unsigned cell_px);
        return cells * cell_px;
    endfunction

endpackage

// File: rtl/point_to_cell.sv
// Maps a probe pixel to an in-map flag and (col,row) by counting cell boundaries.
module point_to_cell import move_pkg::*; #(
    parameter int unsigned GRID_W   = 8,
    parameter int unsigned GRID_H   = 8,
    parameter int unsigned CELL_PX  = 60,
    parameter int unsigned X_ORIGIN = 80,
    parameter int unsigned Y_ORIGIN = 0,
    parameter int unsigned PT_W     = 15,
    parameter int unsigned COL_W    = 3,
    parameter int unsigned ROW_W    = 3
) (
    input  logic [PT_W-1:0]  px,
    input  logic [PT_W-1:0]  py,
    output logic             in_map,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row
);

    localparam logic [PT_W-1:0] X_LO = PT_W'(X_ORIGIN);
    localparam logic [PT_W-1:0] X_HI = PT_W'(X_ORIGIN + map_extent(GRID_W, CELL_PX));
    localparam logic [PT_W-1:0] Y_LO = PT_W'(Y_ORIGIN);
    localparam logic [PT_W-1:0] Y_HI = PT_W'(Y_ORIGIN + map_extent(GRID_H, CELL_PX));

    // Points are two's complement; a set MSB means the arithmetic went negative.
    always_comb begin
        in_map = !px[PT_W-1] && !py[PT_W-1] &&
                 (px >= X_LO) && (px < X_HI) &&
                 (py >= Y_LO) && (py < Y_HI);
    end

    always_comb begin
        col = '0;
        for (int unsigned k = 1; k < GRID_W; k++) begin
            if (px >= PT_W'(X_ORIGIN + k * CELL_PX)) col = col + COL_W'(1);
        end
    end

    always_comb begin
        row = '0;
        for (int unsigned k = 1; k < GRID_H; k++) begin
            if (py >= PT_W'(Y_ORIGIN + k * CELL_PX)) row = row + ROW_W'(1);
        end
    end

endmodule

// File: rtl/move_resolver.sv
// Probes the four box corners for X, Y and XY moves against a latched map and
// resolves a wall-sliding position after a fixed 14-edge check.
module move_resolver import move_pkg::*; #(
    parameter int unsigned GRID_W   = 8,
    parameter int unsigned GRID_H   = 8,
    parameter int unsigned CELL_PX  = 60,
    parameter int unsigned X_ORIGIN = 80,
    parameter int unsigned Y_ORIGIN = 0,
    parameter int unsigned COORD_W  = 10,
    parameter int unsigned COLOR_W  = 2,
    parameter int unsigned STEP_W   = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    input  logic [GRID_W*GRID_H*COLOR_W-1:0]  grid_color,
    input  logic [COORD_W-1:0]                x_pos,
    input  logic [COORD_W-1:0]                y_pos,
    input  logic [COORD_W-1:0]                width,
    input  logic [COORD_W-1:0]                height,
    input  logic [STEP_W-1:0]                 dx,
    input  logic [STEP_W-1:0]                 dy,
    output logic                              ok_x,
    output logic                              ok_y,
    output logic                              ok_xy,
    output logic [COORD_W-1:0]                new_x,
    output logic [COORD_W-1:0]                new_y
);

    localparam int unsigned PW     = COORD_W + STEP_W + 1;
    localparam int unsigned GRID_B = GRID_W * GRID_H * COLOR_W;
    localparam int unsigned COL_W  = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam int unsigned ROW_W  = (GRID_H > 1) ? $clog2(GRID_H) : 1;
    localparam int unsigned IDX_W  = (GRID_B > 1) ? $clog2(GRID_B) : 1;

    state_e              state_q;
    logic [3:0]          cnt_q;
    logic [COORD_W-1:0]  x_q, y_q, w_q, h_q;
    logic [STEP_W-1:0]   dx_q, dy_q;
    logic [GRID_B-1:0]   grid_q;
    logic [PW-1:0]       probe_x_q, probe_y_q;
    logic [PW-1:0]       probe_x_d, probe_y_d;
    cand_e               probe_cand_q;
    logic                probe_vld_q;
    logic                acc_x_q, acc_y_q, acc_xy_q;

    cand_e               cand;
    corner_e             corner;
    logic [COORD_W-1:0]  wm1, hm1;
    logic [PW-1:0]       step_x, step_y;

    logic                in_map;
    logic [COL_W-1:0]    cell_col;
    logic [ROW_W-1:0]    cell_row;
    int unsigned         cell_idx;
    logic [IDX_W-1:0]    bit_base;
    logic                cell_clear;

    logic [COORD_W-1:0]  new_x_d, new_y_d;

    // Zero-size boxes collapse to a single pixel, so the far-corner offset is 0.
    always_comb begin
        cand   = cand_e'(cnt_q[3:2]);
        corner = corner_e'(cnt_q[1:0]);
        wm1    = (w_q == '0) ? '0 : w_q - COORD_W'(1);
        hm1    = (h_q == '0) ? '0 : h_q - COORD_W'(1);
        step_x = (cand != CAND_Y) ? PW'($signed(dx_q)) : '0;
        step_y = (cand != CAND_X) ? PW'($signed(dy_q)) : '0;
        probe_x_d = PW'(x_q) + step_x +
                    (((corner == TR) || (corner == BR)) ? PW'(wm1) : '0);
        probe_y_d = PW'(y_q) + step_y +
                    (((corner == BL) || (corner == BR)) ? PW'(hm1) : '0);
    end

    point_to_cell #(
        .GRID_W   (GRID_W),
        .GRID_H   (GRID_H),
        .CELL_PX  (CELL_PX),
        .X_ORIGIN (X_ORIGIN),
        .Y_ORIGIN (Y_ORIGIN),
        .PT_W     (PW),
        .COL_W    (COL_W),
        .ROW_W    (ROW_W)
    ) u_point_to_cell (
        .px     (probe_x_q),
        .py     (probe_y_q),
        .in_map (in_map),
        .col    (cell_col),
        .row    (cell_row)
    );

    always_comb begin
        cell_idx   = 32'(cell_row) * GRID_W + 32'(cell_col);
        bit_base   = IDX_W'(cell_idx * COLOR_W);
        cell_clear = in_map && (grid_q[bit_base +: COLOR_W] == '0);
    end

    always_comb begin
        new_x_d = x_q;
        new_y_d = y_q;
        if (acc_xy_q) begin
            new_x_d = x_q + COORD_W'($signed(dx_q));
            new_y_d = y_q + COORD_W'($signed(dy_q));
        end else if (acc_x_q) begin
            new_x_d = x_q + COORD_W'($signed(dx_q));
        end else if (acc_y_q) begin
            new_y_d = y_q + COORD_W'($signed(dy_q));
        end
    end

    // Lookup lags the probe register by one edge; DRAIN absorbs the last probe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            w_q          <= '0;
            h_q          <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            grid_q       <= '0;
            probe_x_q    <= '0;
            probe_y_q    <= '0;
            probe_cand_q <= CAND_X;
            probe_vld_q  <= 1'b0;
            acc_x_q      <= 1'b0;
            acc_y_q      <= 1'b0;
            acc_xy_q     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            ok_x         <= 1'b0;
            ok_y         <= 1'b0;
            ok_xy        <= 1'b0;
            new_x        <= '0;
            new_y        <= '0;
        end else begin
            done        <= 1'b0;
            probe_vld_q <= 1'b0;

            if (probe_vld_q) begin
                case (probe_cand_q)
                    CAND_X:  acc_x_q  <= acc_x_q  & cell_clear;
                    CAND_Y:  acc_y_q  <= acc_y_q  & cell_clear;
                    CAND_XY: acc_xy_q <= acc_xy_q & cell_clear;
                    default: ;
                endcase
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        x_q      <= x_pos;
                        y_q      <= y_pos;
                        w_q      <= width;
                        h_q      <= height;
                        dx_q     <= dx;
                        dy_q     <= dy;
                        grid_q   <= grid_color;
                        acc_x_q  <= 1'b1;
                        acc_y_q  <= 1'b1;
                        acc_xy_q <= 1'b1;
                        cnt_q    <= '0;
                        busy     <= 1'b1;
                        state_q  <= PROBE;
                    end
                end
                PROBE: begin
                    probe_x_q    <= probe_x_d;
                    probe_y_q    <= probe_y_d;
                    probe_cand_q <= cand;
                    probe_vld_q  <= 1'b1;
                    cnt_q        <= cnt_q + 4'd1;
                    if (cnt_q == 4'd11) state_q <= DRAIN;
                end
                DRAIN: begin
                    cnt_q   <= '0;
                    state_q <= RESULT;
                end
                RESULT: begin
                    ok_x    <= acc_x_q;
                    ok_y    <= acc_y_q;
                    ok_xy   <= acc_xy_q;
                    new_x   <= new_x_d;
                    new_y   <= new_y_d;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_move_resolver.sv
// Directed checks of move_resolver: sliding, map edge, reset abort, back-to-back.
module tb_move_resolver;

    logic         clk;
    logic         rst;
    logic         start;
    logic         busy;
    logic         done;
    logic [127:0] grid;
    logic [9:0]   x_pos, y_pos, width, height;
    logic [3:0]   dx, dy;
    logic         ok_x, ok_y, ok_xy;
    logic [9:0]   new_x, new_y;

    int total;
    int bad;
    int edges;
    int busy_cycles;
    int done_seen;

    move_resolver #(
        .GRID_W   (8),
        .GRID_H   (8),
        .CELL_PX  (60),
        .X_ORIGIN (80),
        .Y_ORIGIN (0),
        .COORD_W  (10),
        .COLOR_W  (2),
        .STEP_W   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .grid_color (grid),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .width      (width),
        .height     (height),
        .dx         (dx),
        .dy         (dy),
        .ok_x       (ok_x),
        .ok_y       (ok_y),
        .ok_xy      (ok_xy),
        .new_x      (new_x),
        .new_y      (new_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called just after the acceptance edge; counts edges until done is seen.
    task automatic wait_done(input int change_at, output int n_edges, output int n_busy);
        n_edges = 0;
        n_busy  = busy ? 1 : 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (n == change_at) x_pos = 10'd300;
            if (done) begin
                n_edges = n;
                break;
            end
            if (busy) n_busy++;
        end
    endtask

    task automatic setup(input int x, input int y, input int w, input int h,
                         input int sx, input int sy);
        x_pos  = 10'(x);
        y_pos  = 10'(y);
        width  = 10'(w);
        height = 10'(h);
        dx     = 4'(sx);
        dy     = 4'(sy);
    endtask

    task automatic run_one(output int n_edges, output int n_busy);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(0, n_edges, n_busy);
    endtask

    task automatic chk_result(input string tag, input int ex, input int ey, input int exy,
                              input int nx, input int ny);
        chk({tag, "_ok_x"}, int'(ok_x), ex);
        chk({tag, "_ok_y"}, int'(ok_y), ey);
        chk({tag, "_ok_xy"}, int'(ok_xy), exy);
        chk({tag, "_new_x"}, int'(new_x), nx);
        chk({tag, "_new_y"}, int'(new_y), ny);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        start = 1'b0;
        grid  = '0;
        setup(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk_result("rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Empty map, free move in both axes.
        setup(200, 100, 20, 20, 3, -2);
        run_one(edges, busy_cycles);
        chk("t1_latency", edges, 14);
        chk("t1_busy_cycles", busy_cycles, 14);
        chk("t1_busy_at_done", int'(busy), 0);
        chk_result("t1", 1, 1, 1, 203, 98);
        @(posedge clk);
        #1;
        chk("t1_done_pulse", int'(done), 0);
        chk("t1_hold_x", int'(new_x), 203);

        // Reset at cycle 6 of PROBE aborts the check.
        setup(200, 100, 20, 20, 3, -2);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("ab_busy_before", int'(busy), 1);
        rst = 1'b0;
        #1;
        chk("ab_busy", int'(busy), 0);
        chk("ab_done", int'(done), 0);
        chk_result("ab", 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        done_seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        chk("ab_no_done", done_seen, 0);
        chk("ab_idle_busy", int'(busy), 0);
        run_one(edges, busy_cycles);
        chk("ab_rerun_latency", edges, 14);
        chk_result("ab_rerun", 1, 1, 1, 203, 98);

        // Wall at cell (3,1): X blocked, Y slides.
        grid = '0;
        grid[22 +: 2] = 2'b01;
        setup(238, 70, 20, 20, 3, 2);
        run_one(edges, busy_cycles);
        chk("t2_latency", edges, 14);
        chk_result("t2", 0, 1, 0, 238, 72);

        // Left map edge: probe x=79 lies outside.
        grid = '0;
        setup(81, 10, 10, 10, -2, 0);
        run_one(edges, busy_cycles);
        chk("t3_latency", edges, 14);
        chk_result("t3", 0, 1, 0, 81, 10);

        // Box already inside wall cell (0,0), zero step.
        grid = '0;
        grid[1:0] = 2'b11;
        setup(100, 20, 10, 10, 0, 0);
        run_one(edges, busy_cycles);
        chk("t4_latency", edges, 14);
        chk_result("t4", 0, 0, 0, 100, 20);

        // start held high, x_pos changed mid-check, second check accepted at E15.
        grid = '0;
        setup(200, 100, 20, 20, 3, -2);
        start = 1'b1;
        @(posedge clk);
        #1;
        wait_done(5, edges, busy_cycles);
        chk("bb1_latency", edges, 14);
        chk("bb1_busy_cycles", busy_cycles, 14);
        chk_result("bb1", 1, 1, 1, 203, 98);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("bb_e15_done", int'(done), 0);
        chk("bb_e15_busy", int'(busy), 1);
        wait_done(0, edges, busy_cycles);
        chk("bb2_latency", edges, 14);
        chk_result("bb2", 1, 1, 1, 303, 98);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/move_resolver.md
Name: move_resolver

Overview:
- Parametrised successor to the single-result corner collision checker.
- Takes a player bounding box, a signed step (dx, dy) and a snapshot of the cell-colour map.
- Probes all four box corners for three candidate moves: X-only, Y-only and combined XY.
- Returns per-axis validity and a resolved position that slides along walls. Sits between the input/step logic and the player position register.

Parameters:
- GRID_W, 8, map columns
- GRID_H, 8, map rows
- CELL_PX, 60, cell edge length in pixels
- X_ORIGIN, 80, pixel x of the map's left edge
- Y_ORIGIN, 0, pixel y of the map's top edge
- COORD_W, 10, pixel coordinate width
- COLOR_W, 2, bits per map cell
- STEP_W, 4, width of signed dx/dy (two's complement)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- busy  out  1  high from acceptance until done
- done  out  1  one-cycle completion pulse
- grid_color  in  GRID_W*GRID_H*COLOR_W  map; cell (c,r) at bits [(r*GRID_W+c)*COLOR_W +: COLOR_W]; nonzero = wall
- x_pos, y_pos  in  COORD_W  box top-left pixel
- width, height  in  COORD_W  box size in pixels
- dx, dy  in  STEP_W  signed step
- ok_x, ok_y, ok_xy  out  1  candidate move clear
- new_x, new_y  out  COORD_W  resolved position

Behaviour:
- Interface decision: reset rst, asynchronous, active-low; clock clk.
- Reset values: busy=0, done=0, ok_*=0, new_x=0, new_y=0, state=IDLE, probe counter=0. Reset mid-operation aborts the check; no done is produced.
- States: IDLE -> PROBE (12 cycles, cnt 0..11) -> DRAIN (1) -> RESULT (1) -> IDLE.
- On the edge where IDLE and start=1 (E0):
  - Latch x_pos, y_pos, width, height, dx, dy and grid_color. Input changes during the check have no effect.
  - Set busy=1 and clear the internal accumulators.
- Probe order:
  - cnt[3:2] selects the candidate: 0 = X (dx, 0), 1 = Y (0, dy), 2 = XY (dx, dy).
  - cnt[1:0] selects the corner: TL, TR, BL, BR.
  - Corners use offsets 0 or (w-1) and 0 or (h-1). width=0 and height=0 are treated as 1.
- Probe pipeline:
  - The probe point is computed combinationally in signed COORD_W+STEP_W+1 arithmetic, then registered into probe_x/probe_y at E1..E12.
  - The cell lookup on the registered probe point is accumulated (AND of "clear") into acc_x, acc_y or acc_xy at E2..E13.
- Cell lookup:
  - A point is inside the map iff X_ORIGIN <= px < X_ORIGIN+GRID_W*CELL_PX and Y_ORIGIN <= py < Y_ORIGIN+GRID_H*CELL_PX.
  - col = number of boundaries X_ORIGIN+k*CELL_PX (k=1..GRID_W-1) that are <= px; row is found the same way on y. No dividers.
  - A point outside the map, or one with negative intermediate arithmetic, counts as a wall.
- At E14 (RESULT edge):
  - Register ok_x, ok_y and ok_xy.
  - Resolved position: if ok_xy, (x+dx, y+dy); else if ok_x, (x+dx, y); else if ok_y, (x, y+dy); else (x, y), truncated to COORD_W.
  - done=1 and busy=0 for the single following cycle.
- Outputs hold until the next E14 or reset.
- Latency: exactly 14 clock edges from acceptance to done.
- start while busy is ignored (not queued).
- Back-to-back: start may be accepted at E15, while done is high.
- dx=0 or dy=0: probes still run at the zero offset. A box already overlapping a wall yields ok=0 for that candidate.

Decomposition:
- Shared package move_pkg:
  - state encodings (IDLE, PROBE, DRAIN, RESULT)
  - candidate encodings (CAND_X, CAND_Y, CAND_XY)
  - corner encodings (TL, TR, BL, BR)
  - the derived MAP_PX_W and MAP_PX_H constants
- One sub-module, point_to_cell: combinational; takes (px, py) and the grid parameters; outputs in_map, col and row.
- The map-bit select and the FSM stay in move_resolver.

Test Plan:
- Empty map, box (200,100) 20x20, dx=+3, dy=-2 -> ok_x=ok_y=ok_xy=1, new=(203,98), done exactly 14 edges after start, busy high for 14 cycles.
- Wall at cell (3,1) (x 260..319, y 60..119), box (238,70) 20x20, dx=+3, dy=+2 -> ok_x=0, ok_y=1, ok_xy=0, new=(238,72).
- Map-edge clamp: box (81,10) 10x10, dx=-2, dy=0 -> probe x=79 is outside the map, ok_x=ok_xy=0, ok_y=1, new=(81,10).
- Reset asserted at cycle 6 of PROBE -> all outputs 0 immediately and no done pulse. A new start after release completes normally in 14 edges.
- start held high through a check, and x_pos changed mid-check -> one result using the latched inputs; a second check is accepted at E15 and its done arrives 14 edges later.
- Box already inside a wall cell, dx=dy=0 -> ok_x=ok_y=ok_xy=0, new=(x_pos, y_pos).
